// File: rtl/gate_check_pkg.sv
// Shared types for the gate truth-table checker: FSM state encoding,
// vector count and the vector-index type.
package gate_check_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned N_VECTORS = 4;

  typedef logic [1:0] vec_idx_t;

  localparam vec_idx_t LAST_VEC = vec_idx_t'(N_VECTORS - 1);

endpackage

// File: rtl/gate_truth_table_checker_settle_timer.sv
// Settle timer: counts cycles a stimulus vector has been held and flags
// the cycle in which the hold time is used up.
module settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [3:0] TERMINAL = 4'(SETTLE_CYCLES - 1);

  logic [3:0] count_r;

  // Hold-time counter: clear wins over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 4'd0;
    end else if (clear) begin
      count_r <= 4'd0;
    end else if (enable) begin
      count_r <= count_r + 4'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == TERMINAL);

endmodule

// File: rtl/gate_truth_table_checker.sv
// Sweeps {a,b} = 00..11 through an external 2-input gate, compares each
// settled output with EXPECT_TT and reports mask, count and pass.
module gate_truth_table_checker
  import gate_check_pkg::*;
#(
  parameter logic [3:0]  EXPECT_TT     = 4'b1000,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       gate_o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] err_mask
);

  state_t     state_r;
  state_t     state_nxt_s;
  vec_idx_t   vec_idx_r;
  vec_idx_t   vec_idx_nxt_s;
  vec_idx_t   vec_idx_inc_s;
  logic       gate_a_nxt_s;
  logic       gate_b_nxt_s;
  logic       busy_nxt_s;
  logic       done_nxt_s;
  logic       pass_nxt_s;
  logic [2:0] err_count_nxt_s;
  logic [3:0] err_mask_nxt_s;
  logic       mismatch_s;
  logic [2:0] sample_count_s;
  logic [3:0] sample_mask_s;
  logic       timer_clear_s;
  logic       timer_en_s;
  logic       expired_s;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear_s),
    .enable (timer_en_s),
    .expired(expired_s)
  );

  assign timer_en_s    = (state_r == DRIVE);
  assign timer_clear_s = (state_r != DRIVE);

  // Case inequality so an X or Z from the gate is reported as a mismatch.
  assign mismatch_s     = (gate_o !== EXPECT_TT[vec_idx_r]);
  assign sample_count_s = err_count + {2'b00, mismatch_s};
  assign sample_mask_s  = mismatch_s ? (err_mask | (4'b0001 << vec_idx_r)) : err_mask;
  assign vec_idx_inc_s  = vec_idx_r + 2'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = DRIVE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRIVE: begin
        if (expired_s) begin
          state_nxt_s = SAMPLE;
        end else begin
          state_nxt_s = DRIVE;
        end
      end
      SAMPLE: begin
        if (vec_idx_r == LAST_VEC) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = DRIVE;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values for the registered outputs and the vector index.
  always_comb begin
    vec_idx_nxt_s   = vec_idx_r;
    gate_a_nxt_s    = gate_a;
    gate_b_nxt_s    = gate_b;
    busy_nxt_s      = busy;
    done_nxt_s      = 1'b0;
    pass_nxt_s      = pass;
    err_count_nxt_s = err_count;
    err_mask_nxt_s  = err_mask;
    case (state_r)
      IDLE: begin
        gate_a_nxt_s = 1'b0;
        gate_b_nxt_s = 1'b0;
        if (start) begin
          vec_idx_nxt_s   = 2'b00;
          busy_nxt_s      = 1'b1;
          pass_nxt_s      = 1'b0;
          err_count_nxt_s = 3'd0;
          err_mask_nxt_s  = 4'b0000;
        end else begin
          busy_nxt_s = 1'b0;
        end
      end
      DRIVE: begin
        busy_nxt_s = 1'b1;
      end
      SAMPLE: begin
        err_count_nxt_s = sample_count_s;
        err_mask_nxt_s  = sample_mask_s;
        if (vec_idx_r == LAST_VEC) begin
          vec_idx_nxt_s = 2'b00;
          gate_a_nxt_s  = 1'b0;
          gate_b_nxt_s  = 1'b0;
          busy_nxt_s    = 1'b0;
          done_nxt_s    = 1'b1;
          pass_nxt_s    = (sample_count_s == 3'd0);
        end else begin
          vec_idx_nxt_s = vec_idx_inc_s;
          gate_a_nxt_s  = vec_idx_inc_s[1];
          gate_b_nxt_s  = vec_idx_inc_s[0];
        end
      end
      DONE: begin
        gate_a_nxt_s = 1'b0;
        gate_b_nxt_s = 1'b0;
        busy_nxt_s   = 1'b0;
      end
      default: begin
        vec_idx_nxt_s = 2'b00;
        gate_a_nxt_s  = 1'b0;
        gate_b_nxt_s  = 1'b0;
        busy_nxt_s    = 1'b0;
      end
    endcase
  end

  // Output and datapath registers; reset discards any partial sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_idx_r <= 2'b00;
      gate_a    <= 1'b0;
      gate_b    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      err_mask  <= 4'b0000;
    end else begin
      vec_idx_r <= vec_idx_nxt_s;
      gate_a    <= gate_a_nxt_s;
      gate_b    <= gate_b_nxt_s;
      busy      <= busy_nxt_s;
      done      <= done_nxt_s;
      pass      <= pass_nxt_s;
      err_count <= err_count_nxt_s;
      err_mask  <= err_mask_nxt_s;
    end
  end

endmodule
